// File: rtl/memory_access.sv
// Pipeline memory stage: issues loads/stores over a valid/data_ok bus,
// lane-aligns and extends load data, and stalls upstream while a bus access is outstanding.
module memory_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [63:0] in_pc,
  input  logic [31:0] in_raw_instr,
  input  logic [4:0]  in_dst,
  input  logic [63:0] in_aluout,
  input  logic [63:0] in_wdata,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic [1:0]  in_msize,
  input  logic        in_unsigned,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_raw_instr,
  output logic [4:0]  out_dst,
  output logic [63:0] out_aluout,
  output logic [63:0] out_readdata,
  output logic        out_memread,
  output logic        out_misalign,
  output logic        stall_o
);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_next;

  logic [63:0] r_pc, r_addr, r_wdata;
  logic [31:0] r_instr;
  logic [4:0]  r_dst;
  logic        r_memread, r_memwrite, r_unsigned;
  logic [1:0]  r_msize;

  logic        r_out_valid, r_out_memread, r_out_misalign;
  logic [63:0] r_out_pc, r_out_aluout, r_out_readdata;
  logic [31:0] r_out_instr;
  logic [4:0]  r_out_dst;

  logic        w_is_mem, w_in_misalign, w_accept, w_busy;
  logic [2:0]  w_align_mask, w_off;
  logic [7:0]  w_strobe_base;
  logic [63:0] w_raw, w_ldata;

  assign w_is_mem = in_memread | in_memwrite;
  assign w_busy   = (r_state == BUSY);

  always_comb begin
    w_align_mask = '0;
    case (in_msize)
      2'd0: w_align_mask = 3'b000;
      2'd1: w_align_mask = 3'b001;
      2'd2: w_align_mask = 3'b011;
      2'd3: w_align_mask = 3'b111;
      default: w_align_mask = '0;
    endcase
  end

  assign w_in_misalign = |(in_aluout[2:0] & w_align_mask);
  assign w_accept = (r_state == IDLE) & in_valid & w_is_mem & ~w_in_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = BUSY;
      BUSY: if (dresp_data_ok) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_instr    <= '0;
      r_dst      <= '0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_unsigned <= 1'b0;
      r_msize    <= '0;
    end else if ((r_state == IDLE) && in_valid) begin
      r_pc       <= in_pc;
      r_addr     <= in_aluout;
      r_wdata    <= in_wdata;
      r_instr    <= in_raw_instr;
      r_dst      <= in_dst;
      r_memread  <= in_memread;
      r_memwrite <= in_memwrite;
      r_unsigned <= in_unsigned;
      r_msize    <= in_msize;
    end
  end

  assign w_off = r_addr[2:0];

  always_comb begin
    w_strobe_base = '0;
    case (r_msize)
      2'd0: w_strobe_base = 8'h01;
      2'd1: w_strobe_base = 8'h03;
      2'd2: w_strobe_base = 8'h0F;
      2'd3: w_strobe_base = 8'hFF;
      default: w_strobe_base = '0;
    endcase
  end

  assign dreq_valid  = w_busy;
  assign dreq_addr   = w_busy ? r_addr : '0;
  assign dreq_size   = w_busy ? {1'b0, r_msize} : '0;
  assign dreq_strobe = (w_busy & r_memwrite) ? (w_strobe_base << w_off) : '0;
  assign dreq_data   = w_busy ? (r_wdata << {w_off, 3'b000}) : '0;

  assign w_raw = dresp_data >> {w_off, 3'b000};

  always_comb begin
    w_ldata = '0;
    case (r_msize)
      2'd0: w_ldata = r_unsigned ? {56'd0, w_raw[7:0]}  : {{56{w_raw[7]}},  w_raw[7:0]};
      2'd1: w_ldata = r_unsigned ? {48'd0, w_raw[15:0]} : {{48{w_raw[15]}}, w_raw[15:0]};
      2'd2: w_ldata = r_unsigned ? {32'd0, w_raw[31:0]} : {{32{w_raw[31]}}, w_raw[31:0]};
      2'd3: w_ldata = w_raw;
      default: w_ldata = '0;
    endcase
  end

  // Result record: filled directly for 1-cycle ops, or from the latched request on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_memread  <= 1'b0;
      r_out_misalign <= 1'b0;
      r_out_pc       <= '0;
      r_out_aluout   <= '0;
      r_out_readdata <= '0;
      r_out_instr    <= '0;
      r_out_dst      <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if ((r_state == IDLE) && in_valid && (!w_is_mem || w_in_misalign)) begin
        r_out_valid    <= 1'b1;
        r_out_memread  <= in_memread;
        r_out_misalign <= w_is_mem & w_in_misalign;
        r_out_pc       <= in_pc;
        r_out_aluout   <= in_aluout;
        r_out_readdata <= '0;
        r_out_instr    <= in_raw_instr;
        r_out_dst      <= in_dst;
      end else if (w_busy && dresp_data_ok) begin
        r_out_valid    <= 1'b1;
        r_out_memread  <= r_memread;
        r_out_misalign <= 1'b0;
        r_out_pc       <= r_pc;
        r_out_aluout   <= r_addr;
        r_out_readdata <= r_memread ? w_ldata : '0;
        r_out_instr    <= r_instr;
        r_out_dst      <= r_dst;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_pc        = r_out_pc;
  assign out_raw_instr = r_out_instr;
  assign out_dst       = r_out_dst;
  assign out_aluout    = r_out_aluout;
  assign out_readdata  = r_out_readdata;
  assign out_memread   = r_out_memread;
  assign out_misalign  = r_out_misalign;
  assign stall_o       = rst_n & (w_busy | w_accept);

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: inputs change on the falling edge, outputs checked just after.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_pc, in_aluout, in_wdata;
  logic [31:0] in_raw_instr;
  logic [4:0]  in_dst;
  logic        in_memread, in_memwrite, in_unsigned;
  logic [1:0]  in_msize;
  logic        dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        out_valid, out_memread, out_misalign, stall_o;
  logic [63:0] out_pc, out_aluout, out_readdata;
  logic [31:0] out_raw_instr;
  logic [4:0]  out_dst;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  memory_access dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc),
    .in_raw_instr(in_raw_instr), .in_dst(in_dst), .in_aluout(in_aluout),
    .in_wdata(in_wdata), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_msize(in_msize), .in_unsigned(in_unsigned), .dreq_valid(dreq_valid),
    .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_raw_instr(out_raw_instr),
    .out_dst(out_dst), .out_aluout(out_aluout), .out_readdata(out_readdata),
    .out_memread(out_memread), .out_misalign(out_misalign), .stall_o(stall_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic set_op(input logic [63:0] pc, input logic [63:0] addr, input logic rd,
                        input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [63:0] wd);
    in_valid = 1'b1; in_pc = pc; in_aluout = addr; in_memread = rd; in_memwrite = wr;
    in_msize = sz; in_unsigned = uns; in_wdata = wd; in_raw_instr = pc[31:0] ^ 32'h13;
    in_dst = pc[6:2];
  endtask

  // Called at a falling edge with the op on in_*; returns at the falling edge after the data_ok edge.
  task automatic mem_op(input string tag, input int waits, input logic [63:0] exp_addr,
                        input logic [2:0] exp_size, input logic [7:0] exp_strobe,
                        input logic [63:0] exp_data, input logic [63:0] rdata,
                        input int exp_stall);
    int stalls = 0;
    #1 if (stall_o) stalls++;
    @(negedge clk);
    in_valid = 1'b0; in_aluout = 64'hDEAD_BEEF_0BAD_F00D; in_msize = 2'd3;
    in_wdata = '1; in_memwrite = ~in_memwrite;
    for (int k = 0; k <= waits; k++) begin
      #1 if (stall_o) stalls++;
      check({tag, ".dreq_valid"},  dreq_valid,  1'b1);
      check({tag, ".dreq_addr"},   dreq_addr,   exp_addr);
      check({tag, ".dreq_size"},   dreq_size,   exp_size);
      check({tag, ".dreq_strobe"}, dreq_strobe, exp_strobe);
      check({tag, ".dreq_data"},   dreq_data,   exp_data);
      if (k == waits) begin dresp_data_ok = 1'b1; dresp_data = rdata; end
      @(negedge clk);
      dresp_data_ok = 1'b0; dresp_data = '0;
    end
    check({tag, ".stall_cycles"}, stalls, exp_stall);
    check({tag, ".dreq_valid_fall"}, dreq_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_aluout = '0; in_wdata = '0;
    in_raw_instr = '0; in_dst = '0; in_memread = 1'b0; in_memwrite = 1'b0;
    in_msize = '0; in_unsigned = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    #2;
    check("rst.dreq_valid", dreq_valid, 1'b0);
    check("rst.stall", stall_o, 1'b0);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.out_readdata", out_readdata, 64'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU pass-through
    set_op(64'h100, 64'h1234, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0);
    #1 check("alu.stall", stall_o, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    check("alu.out_valid", out_valid, 1'b1);
    check("alu.out_aluout", out_aluout, 64'h1234);
    check("alu.out_pc", out_pc, 64'h100);
    check("alu.out_memread", out_memread, 1'b0);
    check("alu.out_readdata", out_readdata, 64'h0);
    check("alu.dreq_valid", dreq_valid, 1'b0);
    @(negedge clk);
    check("alu.pulse", out_valid, 1'b0);

    // Signed then unsigned byte load, data on the third cycle after acceptance
    set_op(64'h200, 64'h1003, 1'b1, 1'b0, 2'd0, 1'b0, 64'h0);
    mem_op("lbs", 2, 64'h1003, 3'd0, 8'h00, 64'h0, 64'h00000000_80000000, 4);
    check("lbs.out_valid", out_valid, 1'b1);
    check("lbs.out_memread", out_memread, 1'b1);
    check("lbs.out_readdata", out_readdata, 64'hFFFF_FFFF_FFFF_FF80);
    check("lbs.out_pc", out_pc, 64'h200);
    @(negedge clk);
    check("lbs.pulse", out_valid, 1'b0);
    set_op(64'h204, 64'h1003, 1'b1, 1'b0, 2'd0, 1'b1, 64'h0);
    mem_op("lbu", 2, 64'h1003, 3'd0, 8'h00, 64'h0, 64'h00000000_80000000, 4);
    check("lbu.out_readdata", out_readdata, 64'h80);
    @(negedge clk);

    // Half-word store to the top lanes
    set_op(64'h300, 64'h2006, 1'b0, 1'b1, 2'd1, 1'b0, 64'hBEEF);
    mem_op("sh", 3, 64'h2006, 3'd1, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0, 5);
    check("sh.out_valid", out_valid, 1'b1);
    check("sh.out_memread", out_memread, 1'b0);
    check("sh.out_readdata", out_readdata, 64'h0);
    check("sh.out_aluout", out_aluout, 64'h2006);
    @(negedge clk);

    // Misaligned word load
    set_op(64'h400, 64'h2002, 1'b1, 1'b0, 2'd2, 1'b0, 64'h0);
    #1 check("mis.stall", stall_o, 1'b0);
    check("mis.dreq_valid", dreq_valid, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    check("mis.out_valid", out_valid, 1'b1);
    check("mis.out_misalign", out_misalign, 1'b1);
    check("mis.dreq_valid_next", dreq_valid, 1'b0);
    check("mis.out_pc", out_pc, 64'h400);
    @(negedge clk);

    // Back-to-back loads with immediate data_ok
    set_op(64'h500, 64'h3000, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0);
    mem_op("ld1", 0, 64'h3000, 3'd3, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 2);
    check("ld1.out_valid", out_valid, 1'b1);
    check("ld1.out_pc", out_pc, 64'h500);
    check("ld1.out_readdata", out_readdata, 64'h1122_3344_5566_7788);
    set_op(64'h504, 64'h3004, 1'b1, 1'b0, 2'd2, 1'b0, 64'h0);
    mem_op("ld2", 0, 64'h3004, 3'd2, 8'h00, 64'h0, 64'h8765_4321_0000_0000, 2);
    check("ld2.out_valid", out_valid, 1'b1);
    check("ld2.out_pc", out_pc, 64'h504);
    check("ld2.out_misalign", out_misalign, 1'b0);
    check("ld2.out_readdata", out_readdata, 64'hFFFF_FFFF_8765_4321);
    @(negedge clk);

    // Reset while BUSY, then a stray data_ok in IDLE
    set_op(64'h600, 64'h4000, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0);
    @(negedge clk); in_valid = 1'b0;
    check("rstb.dreq_valid_busy", dreq_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("rstb.dreq_valid", dreq_valid, 1'b0);
    check("rstb.stall", stall_o, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    dresp_data_ok = 1'b1; dresp_data = 64'h5A;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dresp_data_ok = 1'b0;
      check("rstb.no_out_valid", out_valid, 1'b0);
      check("rstb.idle_dreq", dreq_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
